cv32e40p_mac_mem_seq: RTL and testbench

//  Memory-side sequencer for the MAC/CON accelerator: turns one burst command (read or write, base addr, len) into
//  OBI data requests. Returns read words with a 1-based word count (feeds mem_rdata/con_data_cnt) and sources write

---
 rtl/cv32e40p_mac_mem_seq_pkg.sv | 13 +
 rtl/cv32e40p_mac_mem_seq.sv | 171 +++++++++++++++++
 tb/tb_cv32e40p_mac_mem_seq.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cv32e40p_mac_mem_seq_pkg.sv
// Shared types and limits for the MAC/CON memory-side burst sequencer.
package cv32e40p_mac_mem_seq_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_ISSUE = 2'd1,
    SEQ_DRAIN = 2'd2,
    SEQ_DONE  = 2'd3
  } mac_seq_state_e;

  localparam int unsigned MAC_SEQ_MAX_LEN = 16;

endpackage

// File: rtl/cv32e40p_mac_mem_seq.sv
// Memory-side sequencer for the MAC/CON accelerator: expands one burst command
// into OBI word requests, returns read words with a 1-based count.
module cv32e40p_mac_mem_seq
  import cv32e40p_mac_mem_seq_pkg::*;
#(
  parameter int unsigned STRIDE_B  = 4,
  parameter int unsigned MAX_OUTST = 2,
  parameter int unsigned LEN_W     = $clog2(MAC_SEQ_MAX_LEN) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [31:0]      cmd_addr_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic             abort_i,
  output logic [31:0]      cnt_o,
  output logic [31:0]      rdata_o,
  output logic             rdata_valid_o,
  input  logic [31:0]      wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             data_req_o,
  input  logic             data_gnt_i,
  output logic [31:0]      data_addr_o,
  output logic             data_we_o,
  output logic [3:0]       data_be_o,
  output logic [31:0]      data_wdata_o,
  input  logic             data_rvalid_i,
  input  logic [31:0]      data_rdata_i,
  input  logic             data_err_i
);

  localparam int unsigned CNT_W = LEN_W + 1;

  mac_seq_state_e   state_r, state_s;
  logic             we_r;
  logic [31:0]      addr_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] issued_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       outst_r;
  logic             abort_seen_r;
  logic             bus_err_seen_r;
  logic [31:0]      rdata_r;
  logic             rdata_valid_r;
  logic             done_r;
  logic             err_r;

  logic             accept_s;
  logic             req_s;
  logic             gnt_s;
  logic             rsp_s;
  logic             active_s;

  // Next-state selection and the combinational OBI request/handshake terms
  always_comb begin
    state_s  = state_r;
    req_s    = 1'b0;
    accept_s = 1'b0;
    active_s = (state_r == SEQ_ISSUE) || (state_r == SEQ_DRAIN);
    case (state_r)
      SEQ_IDLE: begin
        if (cmd_valid_i) begin
          accept_s = 1'b1;
          if (cmd_len_i == {LEN_W{1'b0}}) begin
            state_s = SEQ_DONE;
          end else begin
            state_s = SEQ_ISSUE;
          end
        end else begin
          state_s = SEQ_IDLE;
        end
      end
      SEQ_ISSUE: begin
        // An abort withdraws a pending ungranted request in the same cycle
        if (abort_i || (issued_r == len_r)) begin
          state_s = SEQ_DRAIN;
        end else begin
          state_s = SEQ_ISSUE;
          req_s   = (outst_r < 2'(MAX_OUTST));
        end
      end
      SEQ_DRAIN: begin
        if (outst_r == 2'd0) begin
          state_s = SEQ_DONE;
        end else begin
          state_s = SEQ_DRAIN;
        end
      end
      SEQ_DONE: state_s = SEQ_IDLE;
      default:  state_s = SEQ_IDLE;
    endcase
    gnt_s = req_s && data_gnt_i;
    // Responses with nothing outstanding (e.g. stragglers across a reset) are dropped
    rsp_s = data_rvalid_i && active_s && (outst_r != 2'd0);
  end

  // Burst bookkeeping, bus address and registered accelerator-facing outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= SEQ_IDLE;
      we_r           <= 1'b0;
      addr_r         <= 32'h0000_0000;
      len_r          <= {LEN_W{1'b0}};
      issued_r       <= {LEN_W{1'b0}};
      cnt_r          <= {CNT_W{1'b0}};
      outst_r        <= 2'd0;
      abort_seen_r   <= 1'b0;
      bus_err_seen_r <= 1'b0;
      rdata_r        <= 32'h0000_0000;
      rdata_valid_r  <= 1'b0;
      done_r         <= 1'b0;
      err_r          <= 1'b0;
    end else begin
      state_r       <= state_s;
      done_r        <= (state_r == SEQ_DONE);
      err_r         <= (state_r == SEQ_DONE) && (abort_seen_r || bus_err_seen_r);
      rdata_valid_r <= rsp_s && !we_r;
      if (rsp_s && !we_r) begin
        rdata_r <= data_rdata_i;
      end
      if (accept_s) begin
        we_r           <= cmd_we_i;
        addr_r         <= cmd_addr_i;
        len_r          <= cmd_len_i;
        issued_r       <= {LEN_W{1'b0}};
        cnt_r          <= {CNT_W{1'b0}};
        outst_r        <= 2'd0;
        abort_seen_r   <= 1'b0;
        bus_err_seen_r <= 1'b0;
      end else begin
        if (gnt_s) begin
          issued_r <= issued_r + LEN_W'(1);
          addr_r   <= addr_r + 32'(STRIDE_B);
        end
        // Writes count grants, reads count delivered responses
        if ((gnt_s && we_r) || (rsp_s && !we_r)) begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
        case ({gnt_s, rsp_s})
          2'b10:   outst_r <= outst_r + 2'd1;
          2'b01:   outst_r <= outst_r - 2'd1;
          default: outst_r <= outst_r;
        endcase
        if (rsp_s && data_err_i) begin
          bus_err_seen_r <= 1'b1;
        end
        if (abort_i && active_s) begin
          abort_seen_r <= 1'b1;
        end
      end
    end
  end

  assign cmd_ready_o   = (state_r == SEQ_IDLE);
  assign busy_o        = (state_r != SEQ_IDLE);
  assign cnt_o         = {{(32-CNT_W){1'b0}}, cnt_r};
  assign rdata_o       = rdata_r;
  assign rdata_valid_o = rdata_valid_r;
  assign done_o        = done_r;
  assign err_o         = err_r;
  assign data_req_o    = req_s;
  assign data_addr_o   = addr_r;
  assign data_we_o     = we_r;
  assign data_be_o     = 4'hF;
  assign data_wdata_o  = wdata_i;

endmodule

// File: tb/tb_cv32e40p_mac_mem_seq.sv
// Directed bench for the MAC/CON memory sequencer with a cycle-stepped OBI slave.
module tb_cv32e40p_mac_mem_seq;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [31:0] cmd_addr_i;
  logic [4:0]  cmd_len_i;
  logic        abort_i;
  logic [31:0] cnt_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic        data_req_o;
  logic        data_gnt_i;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;
  logic        data_err_i;

  int n_assert = 0;
  int n_fail   = 0;

  cv32e40p_mac_mem_seq dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i), .abort_i(abort_i),
    .cnt_o(cnt_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o), .wdata_i(wdata_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i), .data_err_i(data_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rpat(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] wpat(input logic [31:0] k);
    return 32'hC0DE_0000 + k;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Runs one burst from accept to done; entered and left 1 time unit after a posedge.
  task automatic run_burst(input string tag, input logic we, input logic [31:0] base,
                           input int len, input int gwait, input int lat, input int abort_at,
                           input int err_at, input int exp_grants, input logic exp_err,
                           input int exp_max);
    int          cyc, grants, strobes, dones, done_cyc, wcnt, outst, max_outst, rsp_idx;
    int          rsp_time[$];
    logic [31:0] rsp_addr[$];
    logic        prev_rsp, rsp_now, abort_pend, aborted, req_now;
    logic [31:0] prev_data;
    cyc = 1; grants = 0; strobes = 0; dones = 0; done_cyc = 0; wcnt = 0;
    outst = 0; max_outst = 0; rsp_idx = 0;
    prev_rsp = 1'b0; abort_pend = 1'b0; aborted = 1'b0; prev_data = 32'h0;

    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = base; cmd_len_i = 5'(len);
    #1;
    chk({tag, "/ready"}, 32'(cmd_ready_o), 32'd1);
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;

    while (cyc <= 300 && !(dones > 0 && cyc > done_cyc + 1)) begin
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0; rsp_now = 1'b0;
      if (rsp_time.size() > 0 && rsp_time[0] == cyc) begin
        data_rvalid_i = 1'b1;
        data_rdata_i  = rpat(rsp_addr[0]);
        data_err_i    = (rsp_idx == err_at);
        rsp_now       = 1'b1;
        rsp_idx++;
        void'(rsp_time.pop_front());
        void'(rsp_addr.pop_front());
      end
      abort_i = abort_pend;
      if (abort_pend) aborted = 1'b1;
      abort_pend = 1'b0;
      wdata_i = wpat(cnt_o);
      #1;
      chk({tag, "/strobe"}, 32'(rdata_valid_o), 32'(prev_rsp));
      if (prev_rsp) begin
        strobes++;
        chk({tag, "/rdata"}, rdata_o, prev_data);
      end
      chk({tag, "/cnt"}, cnt_o, we ? 32'(grants) : 32'(strobes));
      chk({tag, "/err"}, 32'(err_o), done_o ? 32'(exp_err) : 32'd0);
      if (done_o) begin
        dones++;
        done_cyc = cyc;
      end
      req_now = data_req_o;
      if (req_now) begin
        chk({tag, "/req_ok"}, 32'(outst < 2 && grants < len && !aborted), 32'd1);
        chk({tag, "/addr"}, data_addr_o, base + 32'(4 * grants));
        chk({tag, "/we"}, 32'(data_we_o), 32'(we));
        if (we) chk({tag, "/wdata"}, data_wdata_o, wpat(32'(grants)));
        if (wcnt == gwait) begin
          data_gnt_i = 1'b1;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
      @(posedge clk);
      if (req_now && data_gnt_i) begin
        rsp_time.push_back(cyc + lat);
        rsp_addr.push_back(base + 32'(4 * grants));
        grants++;
        outst++;
        if (grants == abort_at) abort_pend = 1'b1;
      end
      if (rsp_now) outst--;
      if (outst > max_outst) max_outst = outst;
      prev_rsp  = rsp_now && !we;
      prev_data = data_rdata_i;
      #1;
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0; abort_i = 1'b0;
      cyc++;
    end

    chk({tag, "/dones"}, 32'(dones), 32'd1);
    chk({tag, "/grants"}, 32'(grants), 32'(exp_grants));
    chk({tag, "/strobes"}, 32'(strobes), we ? 32'd0 : 32'(exp_grants));
    chk({tag, "/max_outst"}, 32'(max_outst), 32'(exp_max));
    chk({tag, "/pending"}, 32'(rsp_time.size()), 32'd0);
    chk({tag, "/busy_end"}, 32'(busy_o), 32'd0);
    chk({tag, "/ready_end"}, 32'(cmd_ready_o), 32'd1);
    if (len == 0) chk({tag, "/done_lat"}, 32'(done_cyc), 32'd2);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_i = 32'h0; cmd_len_i = 5'd0;
    abort_i = 1'b0; wdata_i = 32'h0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    data_rdata_i = 32'h0; data_err_i = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst/cnt", cnt_o, 32'd0);
    chk("rst/rdata", rdata_o, 32'd0);
    chk("rst/rvalid", 32'(rdata_valid_o), 32'd0);
    chk("rst/done", 32'(done_o), 32'd0);
    chk("rst/err", 32'(err_o), 32'd0);
    chk("rst/req", 32'(data_req_o), 32'd0);
    chk("rst/busy", 32'(busy_o), 32'd0);
    chk("rst/ready", 32'(cmd_ready_o), 32'd1);
    chk("rst/addr", data_addr_o, 32'd0);
    chk("rst/be", 32'(data_be_o), 32'hF);

    // Read 9 words, immediate grants, 1-cycle responses
    run_burst("rd9", 1'b0, 32'h0000_1000, 9, 0, 1, -1, -1, 9, 1'b0, 1);
    chk("rd9/addr_end", data_addr_o, 32'h0000_1024);
    // Write 4 words, grant held off 2 cycles per request
    run_burst("wr4", 1'b1, 32'h0000_2000, 4, 2, 1, -1, -1, 4, 1'b0, 1);
    chk("wr4/cnt_end", cnt_o, 32'd4);
    // Read 8 words with 4-cycle responses: outstanding limit reached
    run_burst("rd8", 1'b0, 32'h0000_4000, 8, 0, 4, -1, -1, 8, 1'b0, 2);
    // Zero-length burst
    run_burst("len0", 1'b0, 32'h0000_5000, 0, 0, 1, -1, -1, 0, 1'b0, 0);
    // Abort after the third grant of a 16-word read
    run_burst("abort", 1'b0, 32'h0000_6000, 16, 0, 1, 3, -1, 3, 1'b1, 1);
    // Address wrap past 2^32 with a bus error on the second response
    run_burst("wrap_err", 1'b0, 32'hFFFF_FFF8, 3, 0, 1, -1, 1, 3, 1'b1, 1);
    chk("wrap_err/addr_end", data_addr_o, 32'h0000_0004);

    // Reset in the middle of a read burst with one request outstanding
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 32'h0000_3000; cmd_len_i = 5'd4;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0; data_gnt_i = 1'b1;
    #1;
    chk("midrst/req", 32'(data_req_o), 32'd1);
    @(posedge clk); #1;
    data_gnt_i = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst/cnt", cnt_o, 32'd0);
    chk("midrst/req0", 32'(data_req_o), 32'd0);
    chk("midrst/busy", 32'(busy_o), 32'd0);
    chk("midrst/addr", data_addr_o, 32'd0);
    chk("midrst/rdata", rdata_o, 32'd0);
    data_rvalid_i = 1'b1; data_rdata_i = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    data_rvalid_i = 1'b0;
    chk("midrst/late_strobe", 32'(rdata_valid_o), 32'd0);
    chk("midrst/late_cnt", cnt_o, 32'd0);
    chk("midrst/late_rdata", rdata_o, 32'd0);
    chk("midrst/late_busy", 32'(busy_o), 32'd0);
    run_burst("after_rst", 1'b0, 32'h0000_3000, 2, 0, 1, -1, -1, 2, 1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
